hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage LEGv8 core. It drives the write-enable, flush and bubble controls of the PC, the IF/ID register and the downstream pipeline registers. It resolves three conditions, in priority order: a data-memory busy hold, a taken branch resolved in MEM, and a load-use hazard detected in ID. It also keeps saturating stall and flush counters and a hold watchdog for debug.

## Interface
- CNT_W, 32: width of the performance counters.
- HOLD_MAX, 15: maximum number of consecutive mem_busy cycles before the watchdog fires.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rn, id_rm  in  5 each  source register fields of the instruction in IF/ID.
- id_uses_rn, id_uses_rm  in  1 each  the ID instruction actually reads rn / rm.
- ex_mem_read  in  1  the instruction in ID/EX is a load (LDUR).
- ex_rd  in  5  destination register of the instruction in ID/EX.
- br_taken  in  1  branch taken, resolved from EX/MEM.
- mem_busy  in  1  data memory has not completed its access this cycle.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_bubble  out  1  zero the control fields entering ID/EX.
- exmem_flush  out  1  zero the control fields entering EX/MEM.
- freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- stall_cnt  out  CNT_W  count of cycles with pc_write=0.
- flush_cnt  out  CNT_W  count of flush events.
- hold_timeout  out  1  sticky watchdog flag.

## Operation
- FSM states: RUN and HOLD. Other state: pending_flush (1 bit), hold_len (counts to HOLD_MAX), the two counters, and hold_timeout.
- Load-use hazard (lu) = ex_mem_read & (ex_rd != 31) & ((id_uses_rn & id_rn == ex_rd) | (id_uses_rm & id_rm == ex_rd)). Register X31 (XZR) never creates a hazard.
- The first matching case below applies each cycle.
  1. **reset=1**: every control output is 0. At the edge: state RUN; pending_flush, hold_len, counters and hold_timeout are cleared.
  2. **mem_busy=1**: freeze=1, pc_write=0, ifid_write=0, and no flush or bubble. If br_taken=1, set pending_flush. State becomes HOLD. stall_cnt += 1.
  3. **br_taken | pending_flush** (mem_busy=0): pc_write=1 (the PC loads the branch target), ifid_write=1, ifid_flush=1, idex_bubble=1, exmem_flush=1. lu is ignored because the ID instruction is being squashed. Clear pending_flush. flush_cnt += 1, once per event, even when br_taken and pending_flush are both set. State RUN.
  4. **lu** (no flush, not busy): pc_write=0, ifid_write=0, idex_bubble=1. stall_cnt += 1.
  5. **Otherwise**: pc_write=1, ifid_write=1, and all other control outputs 0.
- hold_len increments on every mem_busy cycle (saturating at HOLD_MAX) and clears on any cycle with mem_busy=0.
- hold_timeout sets at the edge of any mem_busy cycle in which hold_len == HOLD_MAX already. It stays set until reset.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- All control outputs are combinational from the current inputs and registered state, with zero-cycle latency.
- Counters and hold_timeout are registered and reflect an event one cycle later.
- A load-use stall lasts exactly 1 cycle: on the next cycle the load has moved to MEM, and ex_mem_read now refers to the injected bubble.
- A branch arriving during HOLD is flushed on the first cycle with mem_busy=0, exactly once. br_taken remaining high on that release cycle does not produce a second flush.
- Reset asserted mid-HOLD, or with pending_flush set, discards the pending flush. The first post-reset cycle is a plain RUN cycle.
- With HOLD_MAX=N:
  - mem_busy high for N+1 consecutive cycles sets hold_timeout, visible the cycle after the (N+1)-th busy cycle.
  - mem_busy high for N cycles does not set it.

## Test plan
- **Load-use hazard**: ex_mem_read=1, ex_rd=5, id_rn=5, id_uses_rn=1 for one cycle → pc_write=0, ifid_write=0, idex_bubble=1 in that cycle; stall_cnt 0→1 the next cycle.
- **XZR and unused operand**: ex_rd=31, id_rn=31 → no stall. ex_rd=7, id_rm=7, id_uses_rm=0 → no stall.
- **Branch flush over a hazard**: br_taken=1 together with a load-use hazard → ifid_flush=1, idex_bubble=1, exmem_flush=1, pc_write=1; flush_cnt +1; stall_cnt unchanged.
- **Branch during hold**: mem_busy=1 for 3 cycles with br_taken=1 in the 2nd → freeze=1 and no flush for 3 cycles; the 4th cycle (busy=0) flushes once; flush_cnt=1, stall_cnt=3.
- **Watchdog**: HOLD_MAX=4. mem_busy high for 4 cycles → hold_timeout stays 0. mem_busy high for 5 cycles → hold_timeout=1 from cycle 6, and it remains 1 after busy drops until reset.
- **Reset mid-hold and saturation**: reset asserted while in HOLD with pending_flush set → all outputs 0 and counters 0; the first cycle after reset shows no flush. Separately, with CNT_W=4, 20 stall cycles → stall_cnt holds at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage LEGv8 pipeline: memory-busy hold,
// branch flush and load-use stall, plus saturating stall/flush counters and a hold watchdog.
module hazard_ctrl #(
    parameter int CNT_W    = 32,
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             br_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic             freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             hold_timeout
);

    localparam int HL_W = $clog2(HOLD_MAX + 1);
    localparam logic [HL_W-1:0] HOLD_LIMIT = HL_W'(HOLD_MAX);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              pending_flush_q, pending_flush_d;
    logic [HL_W-1:0]   hold_len_q, hold_len_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              hold_timeout_q, hold_timeout_d;

    logic              load_use;
    logic              flush_req;
    logic              stall_inc;
    logic              flush_inc;

    // XZR is never a real destination, so it cannot create a load-use dependency.
    assign load_use = ex_mem_read && (ex_rd != 5'd31) &&
                      ((id_uses_rn && (id_rn == ex_rd)) || (id_uses_rm && (id_rm == ex_rd)));

    // A pending flush only exists while held; it is consumed on the release cycle.
    assign flush_req = br_taken || (pending_flush_q && (state_q == ST_HOLD));

    always_comb begin
        pc_write        = 1'b0;
        ifid_write      = 1'b0;
        ifid_flush      = 1'b0;
        idex_bubble     = 1'b0;
        exmem_flush     = 1'b0;
        freeze          = 1'b0;
        stall_inc       = 1'b0;
        flush_inc       = 1'b0;
        state_d         = ST_RUN;
        pending_flush_d = pending_flush_q;

        if (reset) begin
            pending_flush_d = 1'b0;
        end else if (mem_busy) begin
            freeze    = 1'b1;
            stall_inc = 1'b1;
            state_d   = ST_HOLD;
            if (br_taken) begin
                pending_flush_d = 1'b1;
            end
        end else if (flush_req) begin
            pc_write        = 1'b1;
            ifid_write      = 1'b1;
            ifid_flush      = 1'b1;
            idex_bubble     = 1'b1;
            exmem_flush     = 1'b1;
            flush_inc       = 1'b1;
            pending_flush_d = 1'b0;
        end else if (load_use) begin
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
        end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
        end

        if (!mem_busy) begin
            hold_len_d = '0;
        end else if (hold_len_q == HOLD_LIMIT) begin
            hold_len_d = hold_len_q;
        end else begin
            hold_len_d = hold_len_q + HL_W'(1);
        end

        hold_timeout_d = hold_timeout_q || (mem_busy && (hold_len_q == HOLD_LIMIT));

        stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_RUN;
            pending_flush_q <= 1'b0;
            hold_len_q      <= '0;
            stall_cnt_q     <= '0;
            flush_cnt_q     <= '0;
            hold_timeout_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            pending_flush_q <= pending_flush_d;
            hold_len_q      <= hold_len_d;
            stall_cnt_q     <= stall_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
            hold_timeout_q  <= hold_timeout_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;
    assign hold_timeout = hold_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with CNT_W=4 and HOLD_MAX=4 so saturation and the watchdog are reachable.
module tb_hazard_ctrl;

    localparam int CNT_W    = 4;
    localparam int HOLD_MAX = 4;

    // Control vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, freeze}
    localparam logic [5:0] C_ZERO  = 6'b000000;
    localparam logic [5:0] C_IDLE  = 6'b110000;
    localparam logic [5:0] C_BUSY  = 6'b000001;
    localparam logic [5:0] C_FLUSH = 6'b111110;
    localparam logic [5:0] C_LU    = 6'b000100;

    logic             clk;
    logic             reset;
    logic [4:0]       id_rn, id_rm, ex_rd;
    logic             id_uses_rn, id_uses_rm, ex_mem_read, br_taken, mem_busy;
    logic             pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, freeze;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             hold_timeout;
    logic [5:0]       ctl;

    int n_checks = 0;
    int n_errors = 0;

    hazard_ctrl #(.CNT_W(CNT_W), .HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .reset(reset),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .br_taken(br_taken), .mem_busy(mem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .exmem_flush(exmem_flush), .freeze(freeze),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .hold_timeout(hold_timeout)
    );

    assign ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, freeze};

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        id_rn = 5'd0; id_rm = 5'd0; ex_rd = 5'd0;
        id_uses_rn = 1'b0; id_uses_rm = 1'b0; ex_mem_read = 1'b0;
        br_taken = 1'b0; mem_busy = 1'b0;
    endtask

    // Advance one clock edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_idle();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_lu_rn(input logic [4:0] r);
        ex_mem_read = 1'b1; ex_rd = r; id_rn = r; id_uses_rn = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_idle();
        br_taken = 1'b1; mem_busy = 1'b1;
        set_lu_rn(5'd3);
        #1;
        if (ctl !== C_ZERO) begin $display("FAIL reset_ctl: got %b expected %b", ctl, C_ZERO); n_errors++; end
        n_checks++;
        tick();
        reset = 1'b0;
        set_idle();
        #1;
        if (ctl !== C_IDLE) begin $display("FAIL reset_idle_ctl: got %b expected %b", ctl, C_IDLE); n_errors++; end
        n_checks++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || hold_timeout !== 1'b0) begin
            $display("FAIL reset_state: got stall=%0d flush=%0d to=%b expected 0 0 0", stall_cnt, flush_cnt, hold_timeout);
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_load_use();
        do_reset();
        set_lu_rn(5'd5);
        #1;
        if (ctl !== C_LU) begin $display("FAIL lu_rn_ctl: got %b expected %b", ctl, C_LU); n_errors++; end
        n_checks++;
        tick();
        set_idle();
        #1;
        if (stall_cnt !== 4'd1) begin $display("FAIL lu_rn_stall_cnt: got %0d expected 1", stall_cnt); n_errors++; end
        n_checks++;
        if (ctl !== C_IDLE) begin $display("FAIL lu_release_ctl: got %b expected %b", ctl, C_IDLE); n_errors++; end
        n_checks++;
        ex_mem_read = 1'b1; ex_rd = 5'd12; id_rm = 5'd12; id_uses_rm = 1'b1; id_rn = 5'd1; id_uses_rn = 1'b1;
        #1;
        if (ctl !== C_LU) begin $display("FAIL lu_rm_ctl: got %b expected %b", ctl, C_LU); n_errors++; end
        n_checks++;
        tick();
        set_idle();
        #1;
        if (stall_cnt !== 4'd2) begin $display("FAIL lu_rm_stall_cnt: got %0d expected 2", stall_cnt); n_errors++; end
        n_checks++;
    endtask

    task automatic test_no_hazard();
        set_lu_rn(5'd31);
        #1;
        if (ctl !== C_IDLE) begin $display("FAIL xzr_ctl: got %b expected %b", ctl, C_IDLE); n_errors++; end
        n_checks++;
        set_idle();
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rm = 5'd7; id_uses_rm = 1'b0;
        #1;
        if (ctl !== C_IDLE) begin $display("FAIL unused_rm_ctl: got %b expected %b", ctl, C_IDLE); n_errors++; end
        n_checks++;
        set_idle();
        ex_mem_read = 1'b0; ex_rd = 5'd9; id_rn = 5'd9; id_uses_rn = 1'b1;
        #1;
        if (ctl !== C_IDLE) begin $display("FAIL not_load_ctl: got %b expected %b", ctl, C_IDLE); n_errors++; end
        n_checks++;
        tick();
        set_idle();
        #1;
        if (stall_cnt !== 4'd2) begin $display("FAIL no_hazard_stall_cnt: got %0d expected 2", stall_cnt); n_errors++; end
        n_checks++;
    endtask

    task automatic test_branch_over_hazard();
        set_lu_rn(5'd4);
        br_taken = 1'b1;
        #1;
        if (ctl !== C_FLUSH) begin $display("FAIL br_lu_ctl: got %b expected %b", ctl, C_FLUSH); n_errors++; end
        n_checks++;
        tick();
        set_idle();
        #1;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd2) begin
            $display("FAIL br_lu_counts: got flush=%0d stall=%0d expected 1 2", flush_cnt, stall_cnt);
            n_errors++;
        end
        n_checks++;
        if (ctl !== C_IDLE) begin $display("FAIL br_after_ctl: got %b expected %b", ctl, C_IDLE); n_errors++; end
        n_checks++;
    endtask

    task automatic test_branch_during_hold();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            mem_busy = 1'b1;
            br_taken = (i == 1);
            #1;
            if (ctl !== C_BUSY) begin $display("FAIL hold_ctl_%0d: got %b expected %b", i, ctl, C_BUSY); n_errors++; end
            n_checks++;
            tick();
        end
        set_idle();
        #1;
        if (ctl !== C_FLUSH) begin $display("FAIL hold_release_ctl: got %b expected %b", ctl, C_FLUSH); n_errors++; end
        n_checks++;
        tick();
        #1;
        if (ctl !== C_IDLE) begin $display("FAIL hold_after_ctl: got %b expected %b", ctl, C_IDLE); n_errors++; end
        n_checks++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd3) begin
            $display("FAIL hold_counts: got flush=%0d stall=%0d expected 1 3", flush_cnt, stall_cnt);
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        mem_busy = 1'b1; br_taken = 1'b1;
        tick();
        tick();
        mem_busy = 1'b0;
        #1;
        if (ctl !== C_FLUSH) begin $display("FAIL b2b_release_ctl: got %b expected %b", ctl, C_FLUSH); n_errors++; end
        n_checks++;
        tick();
        br_taken = 1'b0;
        #1;
        if (ctl !== C_IDLE) begin $display("FAIL b2b_after_ctl: got %b expected %b", ctl, C_IDLE); n_errors++; end
        n_checks++;
        if (flush_cnt !== 4'd2 || stall_cnt !== 4'd5) begin
            $display("FAIL b2b_counts: got flush=%0d stall=%0d expected 2 5", flush_cnt, stall_cnt);
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_watchdog();
        do_reset();
        mem_busy = 1'b1;
        for (int i = 0; i < HOLD_MAX; i++) tick();
        mem_busy = 1'b0;
        tick();
        if (hold_timeout !== 1'b0) begin $display("FAIL wd_four_busy: got %b expected 0", hold_timeout); n_errors++; end
        n_checks++;
        mem_busy = 1'b1;
        for (int i = 0; i < HOLD_MAX; i++) tick();
        if (hold_timeout !== 1'b0) begin $display("FAIL wd_before_fire: got %b expected 0", hold_timeout); n_errors++; end
        n_checks++;
        tick();
        if (hold_timeout !== 1'b1) begin $display("FAIL wd_fire: got %b expected 1", hold_timeout); n_errors++; end
        n_checks++;
        mem_busy = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        if (hold_timeout !== 1'b1) begin $display("FAIL wd_sticky: got %b expected 1", hold_timeout); n_errors++; end
        n_checks++;
        if (stall_cnt !== 4'd9) begin $display("FAIL wd_stall_cnt: got %0d expected 9", stall_cnt); n_errors++; end
        n_checks++;
        do_reset();
        if (hold_timeout !== 1'b0) begin $display("FAIL wd_cleared: got %b expected 0", hold_timeout); n_errors++; end
        n_checks++;
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        mem_busy = 1'b1; br_taken = 1'b1;
        tick();
        br_taken = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        if (ctl !== C_ZERO) begin $display("FAIL rst_hold_ctl: got %b expected %b", ctl, C_ZERO); n_errors++; end
        n_checks++;
        tick();
        reset = 1'b0;
        set_idle();
        #1;
        if (ctl !== C_IDLE) begin $display("FAIL rst_hold_first_ctl: got %b expected %b", ctl, C_IDLE); n_errors++; end
        n_checks++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            $display("FAIL rst_hold_counts: got stall=%0d flush=%0d expected 0 0", stall_cnt, flush_cnt);
            n_errors++;
        end
        n_checks++;
        tick();
        if (flush_cnt !== 4'd0) begin $display("FAIL rst_hold_no_flush: got %0d expected 0", flush_cnt); n_errors++; end
        n_checks++;
    endtask

    task automatic test_saturation();
        do_reset();
        set_lu_rn(5'd2);
        for (int i = 0; i < 15; i++) tick();
        if (stall_cnt !== 4'd15) begin $display("FAIL sat_stall_15: got %0d expected 15", stall_cnt); n_errors++; end
        n_checks++;
        for (int i = 0; i < 5; i++) tick();
        if (stall_cnt !== 4'd15) begin $display("FAIL sat_stall_hold: got %0d expected 15", stall_cnt); n_errors++; end
        n_checks++;
        set_idle();
        br_taken = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        if (flush_cnt !== 4'd15) begin $display("FAIL sat_flush_hold: got %0d expected 15", flush_cnt); n_errors++; end
        n_checks++;
        set_idle();
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        tick();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_over_hazard();
        test_branch_during_hold();
        test_back_to_back();
        test_watchdog();
        test_reset_mid_hold();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
